// File: rtl/ola_capture.sv
// Capture stage behind the trigger engine: ring-buffers samples, keeps a pre/post
// trigger window and streams it out oldest-first on a valid/ready port.
module ola_capture #(
    parameter int sample_width = 8,
    parameter int addr_width   = 10
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    ctl_arm,
    input  logic                    ctl_abort,
    input  logic [addr_width-1:0]   ctl_pre,
    input  logic [addr_width-1:0]   ctl_post,
    input  logic                    in_valid,
    input  logic [sample_width-1:0] in_sample,
    input  logic                    in_trigger,
    output logic                    rd_valid,
    output logic [sample_width-1:0] rd_sample,
    output logic                    rd_last,
    input  logic                    rd_ready,
    output logic [2:0]              st_state
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_ARMED = 3'd2,
        ST_POST  = 3'd3,
        ST_READ  = 3'd4
    } state_t;

    localparam int CW = addr_width + 1;
    localparam logic [addr_width-1:0] ZERO_A = {addr_width{1'b0}};
    localparam logic [addr_width-1:0] ONE_A  = {{(addr_width-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]         ZERO_C = {CW{1'b0}};
    localparam logic [CW-1:0]         ONE_C  = {{addr_width{1'b0}}, 1'b1};

    logic [sample_width-1:0] mem_r [2**addr_width];
    logic [sample_width-1:0] mem_q_r;
    state_t                  state_r;
    logic [addr_width-1:0]   wp_r;
    logic [addr_width-1:0]   ta_r;
    logic [addr_width-1:0]   pre_r;
    logic [addr_width-1:0]   post_r;
    logic [CW-1:0]           n_r;
    logic [CW-1:0]           cnt_r;
    logic                    q_valid_r;
    logic                    q_last_r;
    logic                    rd_valid_r;
    logic [sample_width-1:0] rd_sample_r;
    logic                    rd_last_r;

    logic [addr_width-1:0]   post_eff_s;
    logic [addr_width-1:0]   room_s;
    logic [addr_width-1:0]   pre_eff_s;
    logic [addr_width-1:0]   raddr_s;
    logic [CW-1:0]           cnt_inc_s;
    logic                    wr_en_s;
    logic                    out_free_s;
    logic                    q_adv_s;
    logic                    issue_s;
    logic                    xfer_last_s;

    // Effective counts, write enable and the prefetch/skid handshake terms.
    always_comb begin
        post_eff_s  = (ctl_post == ZERO_A) ? ONE_A : ctl_post;
        // D - post_eff, expressed modulo D since post_eff is never zero
        room_s      = ZERO_A - post_eff_s;
        pre_eff_s   = (ctl_pre < room_s) ? ctl_pre : room_s;
        cnt_inc_s   = cnt_r + ONE_C;
        raddr_s     = ta_r - pre_r + cnt_r[addr_width-1:0];
        wr_en_s     = in_valid && ((state_r == ST_FILL) || (state_r == ST_ARMED) ||
                                   (state_r == ST_POST));
        out_free_s  = !rd_valid_r || rd_ready;
        q_adv_s     = q_valid_r && out_free_s;
        issue_s     = (state_r == ST_READ) && (cnt_r < n_r) && (!q_valid_r || out_free_s);
        xfer_last_s = rd_valid_r && rd_ready && rd_last_r;
    end

    // Sample memory: synchronous write and synchronous (prefetch) read, no reset.
    always_ff @(posedge clock) begin
        if (wr_en_s) begin
            mem_r[wp_r] <= in_sample;
        end
        if (issue_s) begin
            mem_q_r <= mem_r[raddr_s];
        end
    end

    // Free-running ring write pointer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wp_r <= ZERO_A;
        end else if (wr_en_s) begin
            wp_r <= wp_r + ONE_A;
        end
    end

    // Capture sequencer and two-stage read pipeline (prefetch register + output register).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            ta_r        <= ZERO_A;
            pre_r       <= ZERO_A;
            post_r      <= ZERO_A;
            n_r         <= ZERO_C;
            cnt_r       <= ZERO_C;
            q_valid_r   <= 1'b0;
            q_last_r    <= 1'b0;
            rd_valid_r  <= 1'b0;
            rd_sample_r <= {sample_width{1'b0}};
            rd_last_r   <= 1'b0;
        end else if (ctl_abort) begin
            state_r    <= ST_IDLE;
            q_valid_r  <= 1'b0;
            rd_valid_r <= 1'b0;
            rd_last_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (ctl_arm) begin
                        pre_r   <= pre_eff_s;
                        post_r  <= post_eff_s;
                        n_r     <= {1'b0, pre_eff_s} + {1'b0, post_eff_s};
                        cnt_r   <= ZERO_C;
                        state_r <= (pre_eff_s == ZERO_A) ? ST_ARMED : ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (in_valid) begin
                        cnt_r <= cnt_inc_s;
                        if (cnt_inc_s == {1'b0, pre_r}) begin
                            state_r <= ST_ARMED;
                        end
                    end
                end
                ST_ARMED: begin
                    if (in_valid && in_trigger) begin
                        ta_r <= wp_r;
                        if (post_r == ONE_A) begin
                            cnt_r   <= ZERO_C;
                            state_r <= ST_READ;
                        end else begin
                            cnt_r   <= ONE_C;
                            state_r <= ST_POST;
                        end
                    end
                end
                ST_POST: begin
                    if (in_valid) begin
                        if (cnt_inc_s == {1'b0, post_r}) begin
                            cnt_r   <= ZERO_C;
                            state_r <= ST_READ;
                        end else begin
                            cnt_r <= cnt_inc_s;
                        end
                    end
                end
                ST_READ: begin
                    if (issue_s) begin
                        cnt_r <= cnt_inc_s;
                    end
                    if (xfer_last_s) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase

            if (issue_s) begin
                q_valid_r <= 1'b1;
                q_last_r  <= (cnt_inc_s == n_r);
            end else if (q_adv_s) begin
                q_valid_r <= 1'b0;
            end

            if (q_adv_s) begin
                rd_valid_r  <= 1'b1;
                rd_sample_r <= mem_q_r;
                rd_last_r   <= q_last_r;
            end else if (rd_valid_r && rd_ready) begin
                rd_valid_r <= 1'b0;
                rd_last_r  <= 1'b0;
            end
        end
    end

    assign rd_valid  = rd_valid_r;
    assign rd_sample = rd_sample_r;
    assign rd_last   = rd_last_r;
    assign st_state  = state_r;

endmodule

// File: tb/tb_ola_capture.sv
// Randomised and directed bench for ola_capture (D=16); expected windows come from
// the log of samples offered since arm, using the pre/trigger/post window rules.
module tb_ola_capture;

    logic       clock = 1'b0;
    logic       reset;
    logic       ctl_arm, ctl_abort;
    logic [3:0] ctl_pre, ctl_post;
    logic       in_valid, in_trigger, rd_ready;
    logic [7:0] in_sample;
    logic       rd_valid, rd_last;
    logic [7:0] rd_sample;
    logic [2:0] st_state;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [7:0] q_data[$];
    bit         q_trig[$];
    int         q_edge[$];

    ola_capture #(.sample_width(8), .addr_width(4)) dut (
        .clock(clock), .reset(reset), .ctl_arm(ctl_arm), .ctl_abort(ctl_abort),
        .ctl_pre(ctl_pre), .ctl_post(ctl_post), .in_valid(in_valid),
        .in_sample(in_sample), .in_trigger(in_trigger), .rd_valid(rd_valid),
        .rd_sample(rd_sample), .rd_last(rd_last), .rd_ready(rd_ready),
        .st_state(st_state)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    // Offer samples until the DUT reports stop_state; every valid sample is logged.
    task automatic feed(input int trig_a, input int trig_b, input bit rnd, input int gap,
                        input logic [2:0] stop_state);
        int  c;
        int  idx;
        bit  v;
        c = 0;
        while (st_state != stop_state && c < 400) begin
            idx        = q_data.size();
            v          = (gap == 0) ? ($urandom_range(0, 1) == 1) : ((c % gap) == 0);
            in_valid   = v;
            in_sample  = rnd ? 8'($urandom) : 8'(idx);
            in_trigger = (idx == trig_a) || (idx == trig_b) ||
                         (rnd && (($urandom_range(0, 4) == 0) || idx > 80));
            tick();
            if (v) begin
                q_data.push_back(in_sample);
                q_trig.push_back(in_trigger);
                q_edge.push_back(cyc);
            end
            c++;
        end
        in_valid   = 1'b0;
        in_trigger = 1'b0;
        if (c >= 400) check("feed_timeout", st_state, stop_state);
    endtask

    task automatic arm(input int pre, input int post);
        q_data.delete();
        q_trig.delete();
        q_edge.delete();
        ctl_pre  = 4'(pre);
        ctl_post = 4'(post);
        ctl_arm  = 1'b1;
        tick();
        ctl_arm  = 1'b0;
    endtask

    // Drain the window and compare against the logged samples.
    task automatic read_out(input int pre, input int post, input int rmode);
        int  pe, ppe, t, n, fe, got, first_c, last_c, idx;
        bit  prev_stall, seen;
        logic [9:0] held;
        ppe = (post == 0) ? 1 : post;
        pe  = (pre < 16 - ppe) ? pre : 16 - ppe;
        n   = pe + ppe;
        t   = -1;
        for (int i = pe; i < q_data.size(); i++) if (q_trig[i] && t < 0) t = i;
        if (t < 0) begin
            check("trig_found", 0, 1);
            t = pe;
        end
        check("n_writes", q_data.size(), t + ppe);
        fe = (q_data.size() >= t + ppe) ? q_edge[t + ppe - 1] : -1;
        got = 0; first_c = 0; last_c = 0; prev_stall = 0; seen = 0; held = '0;
        for (int c = 0; c < 200 && got < n; c++) begin
            case (rmode)
                0: rd_ready = 1'b1;
                1: rd_ready = (c % 2) == 1;
                2: rd_ready = !(c >= 4 && c < 7);
                default: rd_ready = ($urandom_range(0, 1) == 1);
            endcase
            if (rd_valid && !seen) begin
                seen    = 1;
                first_c = cyc;
                if (fe >= 0) check("rise_latency", cyc, fe + 2);
            end
            if (prev_stall) check("stall_hold", {rd_valid, rd_last, rd_sample}, held);
            if (rd_valid && rd_ready) begin
                idx = t - pe + got;
                check("rd_sample", rd_sample, (idx < q_data.size()) ? q_data[idx] : 8'h00);
                check("rd_last", rd_last, (got == n - 1) ? 1 : 0);
                got++;
                last_c = cyc;
            end
            prev_stall = rd_valid && !rd_ready;
            held       = {rd_valid, rd_last, rd_sample};
            tick();
        end
        rd_ready = 1'b0;
        check("read_count", got, n);
        if (rmode == 0) check("throughput", last_c - first_c + 1, n);
        check("idle_after", st_state, 0);
        check("rdv_after", rd_valid, 0);
        if (st_state != 3'd0) begin
            ctl_abort = 1'b1;
            tick();
            ctl_abort = 1'b0;
        end
    endtask

    task automatic capture(input int pre, input int post, input int trig_a, input int trig_b,
                           input bit rnd, input int gap, input int rmode);
        arm(pre, post);
        check("arm_state", st_state, ((post == 0 ? 1 : post) >= 16 || pre == 0) ? 2 : 1);
        feed(trig_a, trig_b, rnd, gap, 3'd4);
        read_out(pre, post, rmode);
    endtask

    initial begin
        bit any_v;
        reset = 1'b1; ctl_arm = 0; ctl_abort = 0; ctl_pre = 0; ctl_post = 0;
        in_valid = 0; in_trigger = 0; in_sample = 0; rd_ready = 0;
        tick(); tick();
        check("rst_state", st_state, 0);
        check("rst_valid", rd_valid, 0);
        check("rst_sample", rd_sample, 0);
        check("rst_last", rd_last, 0);
        reset = 1'b0;
        tick();

        capture(4, 4, 32, -1, 0, 1, 0);   // basic: reads 0x1C..0x23
        capture(4, 4, 1, 4, 0, 1, 0);     // trigger in FILL ignored
        capture(12, 8, 40, -1, 0, 1, 0);  // clip to pre 8, ring wrap
        capture(4, 4, 10, -1, 0, 1, 2);   // 3-cycle stall
        capture(4, 4, 10, -1, 0, 1, 1);   // toggling ready
        capture(4, 4, 10, -1, 0, 3, 1);   // input every third cycle
        capture(15, 0, 20, -1, 0, 1, 0);  // full-depth window
        capture(0, 0, 3, -1, 0, 1, 0);    // single-sample window

        // abort in POST
        arm(2, 4);
        feed(5, -1, 0, 1, 3'd3);
        ctl_abort = 1'b1;
        tick();
        ctl_abort = 1'b0;
        check("abort_post_state", st_state, 0);
        any_v = 0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_trigger = 1'b1; rd_ready = 1'b1;
            tick();
            any_v |= rd_valid;
        end
        in_valid = 0; in_trigger = 0; rd_ready = 0;
        check("abort_post_quiet", any_v, 0);
        check("abort_post_idle", st_state, 0);

        // abort and arm together in ARMED
        arm(1, 3);
        feed(-1, -1, 0, 1, 3'd2);
        ctl_abort = 1'b1; ctl_arm = 1'b1;
        tick();
        ctl_abort = 1'b0; ctl_arm = 1'b0;
        check("abort_arm_state", st_state, 0);
        check("abort_arm_valid", rd_valid, 0);
        capture(0, 1, 3, -1, 0, 1, 0);

        // asynchronous reset during READ
        arm(3, 2);
        feed(5, -1, 0, 1, 3'd4);
        rd_ready = 1'b0;
        for (int i = 0; i < 4 && !rd_valid; i++) tick();
        check("pre_reset_valid", rd_valid, 1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_state", st_state, 0);
        check("async_rst_valid", rd_valid, 0);
        check("async_rst_sample", rd_sample, 0);
        check("async_rst_last", rd_last, 0);
        #2 reset = 1'b0;
        tick();
        check("post_reset_state", st_state, 0);

        for (int k = 0; k < 14; k++) begin
            capture($urandom_range(0, 15), $urandom_range(0, 15), -1, -1, 1,
                    $urandom_range(0, 2), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ola_capture.md
# ola_capture

Recording stage directly downstream of the trigger engine. It consumes the engine's valid/sample/trigger stream into a circular sample memory. It keeps a programmable number of pre-trigger samples, records a programmable number of post-trigger samples, then streams the captured window out oldest-first over a valid/ready read port. Armed and aborted by the control block; one capture per arm.

## Interface
Parameters:
- sample_width, 8, width of one sample.
- addr_width, 10, memory address width; depth D = 2^addr_width samples.

Ports:
- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- ctl_arm  in  1  single-cycle pulse; starts a capture from IDLE.
- ctl_abort  in  1  single-cycle pulse; returns to IDLE from any state.
- ctl_pre  in  addr_width  number of pre-trigger samples; latched on accepted arm.
- ctl_post  in  addr_width  number of post-trigger samples, trigger sample included; latched on accepted arm.
- in_valid  in  1  sample strobe from trigger engine.
- in_sample  in  sample_width  sample data.
- in_trigger  in  1  trigger flag, qualified by in_valid.
- rd_valid  out  1  read data valid.
- rd_sample  out  sample_width  read data.
- rd_last  out  1  marks final sample of the window.
- rd_ready  in  1  consumer accepts rd_sample.
- st_state  out  3  current state: 0 IDLE, 1 FILL, 2 ARMED, 3 POST, 4 READ.

## Operation
- Effective counts are computed at arm:
  - post_eff = max(ctl_post, 1).
  - pre_eff = min(ctl_pre, D − post_eff).
  - Window length N = pre_eff + post_eff ≤ D.
- Write pointer wp is addr_width wide and wraps modulo D.
  - In FILL, ARMED and POST, every cycle with in_valid=1 writes in_sample at wp, then wp+1.
  - Cycles with in_valid=0 change nothing.
- IDLE: no writes. On ctl_arm, latch counts and clear the sample counter. Go to FILL, or to ARMED directly if pre_eff=0.
- FILL: count written samples. After the pre_eff-th write, go to ARMED. in_trigger is ignored in FILL.
- ARMED: the ring keeps overwriting. A sample with in_valid=1 and in_trigger=1 is written and counted as post sample 1, and its address is latched as ta.
  - If post_eff=1, go to READ; otherwise go to POST.
- POST: count writes; in_trigger is ignored. After the post_eff-th post sample, go to READ.
- READ: no writes; in_valid is ignored.
  - Read addresses run (ta − pre_eff) mod D upward for N samples.
  - rd_last=1 with the N-th sample.
  - After the transfer of the sample with rd_last, go to IDLE.
- Handshake:
  - A transfer occurs when rd_valid & rd_ready.
  - While rd_valid=1 and rd_ready=0, rd_sample and rd_last hold stable.
  - rd_valid never drops before the transfer.
  - Full throughput is required: one transfer per cycle while rd_ready=1, so the memory read must be prefetched.
- ctl_abort: next state is IDLE, and rd_valid/rd_last go to 0. Abort wins over a simultaneous arm.
- ctl_arm outside IDLE is ignored.
- Memory contents are not reset.

## Timing
- Reset values: st_state=0, rd_valid=0, rd_sample=0, rd_last=0. wp, counters and ta are also 0.
- st_state is registered. It changes on the edge after the causing event; for example, arm at edge k gives st_state=1 after edge k.
- Memory write latency is 1 cycle; synchronous-read memory.
- rd_valid rises exactly 2 clocks after the edge that wrote the final post sample.
- Consecutive samples appear on back-to-back cycles while rd_ready=1.
- st_state=0 on the cycle after the rd_last transfer. A new arm is accepted on that cycle.
- Reset or abort mid-capture discards the window. Nothing is output.

## Test plan
- Basic capture, D=16, pre=4, post=4. Arm, then feed samples 0x00, 0x01, … every cycle with trigger on 0x20. Required: exactly 8 reads 0x1C–0x23, rd_last on 0x23, then st_state=0.
- Trigger ignored during FILL, D=16, pre=4, post=4. Arm, feed from 0x00, trigger flagged on 0x01 and 0x04. Required: read 0x00–0x07; the trigger on 0x01 has no effect.
- Clipping and wrap, D=16, pre=12, post=8. Run 40 samples before trigger on 0x28. Required: pre_eff=8, read 0x20–0x2F, read pointer wraps correctly.
- Back-pressure: drop rd_ready for 3 cycles mid-readout, and toggle rd_ready every cycle. Required: rd_sample stable while stalled, no sample lost or duplicated, throughput of 1/cycle when rd_ready=1.
- Abort and re-arm: abort in POST, and separately assert abort and arm in the same cycle in ARMED. Required: st_state=0 next cycle, no rd_valid. A following arm with pre=0, post=1 captures only the trigger sample, with rd_last=1.
- Gapped input and reset: in_valid high every third cycle, and assert reset asynchronously during READ. Required: gaps don't advance counts. On reset, outputs go to reset values immediately and state is IDLE.
